add_tree_pipe: RTL and testbench

Parametrised, pipelined multi-operand adder tree. Sums N_IN unsigned operands of W bits each through a binary tree with one register stage per tree level, under a valid/ready handshake. It succeeds the fixed 4-operand combinational adder tree and serves as the reduction engine for popcount and dot-product datapaths. An optional accumulate mode sums multi-beat packets.

---
 rtl/add_tree_pkg.sv | 23 ++
 rtl/add_tree_level.sv | 38 +++
 rtl/add_tree_pipe.sv | 101 ++++++++++
 tb/tb_add_tree_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_tree_pkg.sv
// Shared constants and helpers for the pipelined adder tree.
package add_tree_pkg;

    localparam int DEF_N_IN = 8;
    localparam int DEF_W    = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int LOG2N(input int n);
        return clog2(n);
    endfunction

    function automatic int SUM_W(input int w, input int n);
        return w + clog2(n);
    endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered tree level: N inputs of WI bits reduced to N/2 sums of WI+1 bits.
module add_tree_level #(
    parameter int N  = 2,
    parameter int WI = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [N*WI-1:0]            in_data,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [(N/2)*(WI+1)-1:0]    out_data
);

    logic [(N/2)*(WI+1)-1:0] sum;

    always_comb begin
        sum = '0;
        for (int j = 0; j < N/2; j++)
            sum[j*(WI+1) +: WI+1] = {1'b0, in_data[2*j*WI +: WI]}
                                  + {1'b0, in_data[(2*j+1)*WI +: WI]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_last  <= in_last;
            out_data  <= sum;
        end
    end

endmodule

// File: rtl/add_tree_pipe.sv
// Pipelined N_IN-operand adder tree with valid/ready and global stall.
// Define ADD_TREE_ACCUM_EN to add a packet accumulator stage after the tree.
module add_tree_pipe
    import add_tree_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int W     = DEF_W,
    parameter int ACC_W = W + clog2(N_IN) + 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*W-1:0]     in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef ADD_TREE_ACCUM_EN
    output logic [ACC_W-1:0]      out_sum
`else
    output logic [SUM_W(W, N_IN)-1:0] out_sum
`endif
);

    localparam int L  = LOG2N(N_IN);
    localparam int SW = SUM_W(W, N_IN);

    logic stall, xfer;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign xfer     = in_valid && in_ready;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int NK = N_IN >> k;
        localparam int WK = W + k;
        logic [NK*WK-1:0]          din;
        logic                      vin, lin;
        logic [(NK/2)*(WK+1)-1:0]  dout;
        logic                      vout, lout;

        if (k == 0) begin : g_src
            // Gate with the transfer so bubbles carry zeros down the tree.
            assign din = xfer ? in_data : '0;
            assign vin = xfer;
            assign lin = xfer && in_last;
        end else begin : g_src
            assign din = g_lvl[k-1].dout;
            assign vin = g_lvl[k-1].vout;
            assign lin = g_lvl[k-1].lout;
        end

        add_tree_level #(.N(NK), .WI(WK)) u_lvl (
            .clk       (clk),
            .rst       (rst),
            .en        (!stall),
            .in_valid  (vin),
            .in_last   (lin),
            .in_data   (din),
            .out_valid (vout),
            .out_last  (lout),
            .out_data  (dout)
        );
    end

    logic [SW-1:0] tree_sum;
    logic          tree_valid, tree_last;
    assign tree_sum   = g_lvl[L-1].dout;
    assign tree_valid = g_lvl[L-1].vout;
    assign tree_last  = g_lvl[L-1].lout;

`ifdef ADD_TREE_ACCUM_EN
    logic [ACC_W-1:0] acc, acc_sum;
    assign acc_sum = acc + ACC_W'(tree_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (!stall) begin
            out_valid <= 1'b0;
            if (tree_valid) begin
                if (tree_last) begin
                    out_sum   <= acc_sum;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end
`else
    localparam int unused_acc_w = ACC_W;
    logic unused_last;
    assign unused_last = tree_last;
    assign out_valid   = tree_valid;
    assign out_sum     = tree_sum;
`endif

endmodule

// File: tb/tb_add_tree_pipe.sv
// Randomised self-checking bench for add_tree_pipe against an arithmetic reference.
module tb_add_tree_pipe;
    import add_tree_pkg::*;

`ifdef ADD_TREE_ACCUM_EN
    localparam int ACC = 1;
`else
    localparam int ACC = 0;
`endif
    localparam int N   = 8;
    localparam int W   = 4;
    localparam int L   = 3;
    localparam int LAT = L + ACC;
    localparam int OW  = ACC ? (W + L + 8) : (W + L);
    localparam int OW2  = ACC ? (1 + 1 + 8) : 2;
    localparam int OW64 = ACC ? (32 + 6 + 8) : 38;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            in_valid, in_ready, in_last, out_valid, out_ready;
    logic [N*W-1:0]  in_data;
    logic [OW-1:0]   out_sum;

    add_tree_pipe #(.N_IN(N), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum)
    );

    logic            v2, ir2, ov2, r2, l2;
    logic [1:0]      d2;
    logic [OW2-1:0]  os2;
    add_tree_pipe #(.N_IN(2), .W(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_data(d2),
        .in_last(l2), .out_valid(ov2), .out_ready(r2), .out_sum(os2)
    );

    logic              v64, ir64, ov64, r64, l64;
    logic [64*32-1:0]  d64;
    logic [OW64-1:0]   os64;
    add_tree_pipe #(.N_IN(64), .W(32)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(ir64), .in_data(d64),
        .in_last(l64), .out_valid(ov64), .out_ready(r64), .out_sum(os64)
    );

`ifdef ADD_TREE_ACCUM_EN
    logic          av, air, aov, ar, al;
    logic [15:0]   ad;
    logic [13:0]   aos;
    add_tree_pipe #(.N_IN(4), .W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(av), .in_ready(air), .in_data(ad),
        .in_last(al), .out_valid(aov), .out_ready(ar), .out_sum(aos)
    );
`endif

    int n_checks = 0;
    int n_fail   = 0;
    longint unsigned exp_q[$];

    function automatic longint unsigned ref_sum(input logic [N*W-1:0] d);
        longint unsigned s;
        s = 0;
        for (int i = 0; i < N; i++) s += d[i*W +: W];
        return s;
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = 4'($urandom_range(0, 15));
        return d;
    endfunction

    // Drive one cycle on the main DUT; report what was seen before the edge.
    task automatic step(input logic v, input logic [N*W-1:0] d, input logic rdy,
                        output logic ax, output logic ox, output logic ir,
                        output logic ov, output logic [OW-1:0] s);
        in_valid = v; in_data = d; in_last = 1'b1; out_ready = rdy;
        #1;
        ir = in_ready; ov = out_valid; s = out_sum;
        ax = v && in_ready;
        ox = out_valid && rdy;
        if (ax) exp_q.push_back(ref_sum(d));
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
        v2 = 0; d2 = '0; l2 = 1; r2 = 1;
        v64 = 0; d64 = '0; l64 = 1; r64 = 1;
`ifdef ADD_TREE_ACCUM_EN
        av = 0; ad = '0; al = 0; ar = 1;
`endif
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum: got %0d want 0", out_sum); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic ax, ox, ir, ov; logic [OW-1:0] s;
        int lat;
        longint unsigned e;
        step(1'b1, {N{4'hF}}, 1'b1, ax, ox, ir, ov, s);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            step(1'b0, '0, 1'b1, ax, ox, ir, ov, s);
            lat++;
        end
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (out_sum !== OW'(120)) begin n_fail++; $display("FAIL single_sum: got %0d want 120", out_sum); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        n_checks++; if (out_sum !== OW'(e)) begin n_fail++; $display("FAIL single_ref: got %0d want %0d", out_sum, e); end
        step(1'b0, '0, 1'b1, ax, ox, ir, ov, s);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_stream();
        logic ax, ox, ir, ov; logic [OW-1:0] s;
        logic [3:0] b;
        int n_out, t0;
        longint unsigned e;
        n_out = 0; t0 = -1;
        for (int t = 0; t < 20; t++) begin
            b = 4'(t);
            step(t < 8, {N{b}}, 1'b1, ax, ox, ir, ov, s);
            if (ox) begin
                if (t0 < 0) t0 = t;
                n_checks++; if (t != t0 + n_out) begin n_fail++; $display("FAIL stream_consecutive: out at %0d want %0d", t, t0 + n_out); end
                n_checks++; if (s !== OW'(8 * n_out)) begin n_fail++; $display("FAIL stream_value: got %0d want %0d", s, 8 * n_out); end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
                n_checks++; if (s !== OW'(e)) begin n_fail++; $display("FAIL stream_ref: got %0d want %0d", s, e); end
                n_out++;
            end
        end
        n_checks++; if (n_out != 8) begin n_fail++; $display("FAIL stream_count: got %0d want 8", n_out); end
    endtask

    task automatic test_backpressure();
        logic ax, ox, ir, ov; logic [OW-1:0] s, held;
        logic rdy;
        longint unsigned e;
        held = '0;
        for (int t = 0; t < 30; t++) begin
            rdy = !(t >= 5 && t < 10);
            step(t < 14, rand_data(), rdy, ax, ox, ir, ov, s);
            if (t == 5) held = s;
            if (!rdy) begin
                n_checks++; if (ov !== 1'b1 || ir !== 1'b0) begin n_fail++; $display("FAIL bp_stall: out_valid %b in_ready %b want 1 0", ov, ir); end
                n_checks++; if (s !== held) begin n_fail++; $display("FAIL bp_hold: got %0d want %0d", s, held); end
            end
            if (ox) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
                n_checks++; if (s !== OW'(e)) begin n_fail++; $display("FAIL bp_ref: got %0d want %0d", s, e); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_lost: %0d beats outstanding want 0", exp_q.size()); end
    endtask

    task automatic test_random();
        logic ax, ox, ir, ov; logic [OW-1:0] s, ps;
        logic pstall, v, rdy;
        longint unsigned e;
        pstall = 0; ps = '0;
        for (int t = 0; t < 330; t++) begin
            v   = (t < 300) && ($urandom_range(0, 3) != 0);
            rdy = (t >= 300) || ($urandom_range(0, 9) < 7);
            step(v, rand_data(), rdy, ax, ox, ir, ov, s);
            if (pstall) begin
                n_checks++; if (ov !== 1'b1 || s !== ps) begin n_fail++; $display("FAIL rand_stable: valid %b sum %0d want 1 %0d", ov, s, ps); end
            end
            pstall = ov && !rdy; ps = s;
            if (ox) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
                n_checks++; if (s !== OW'(e)) begin n_fail++; $display("FAIL rand_ref: got %0d want %0d", s, e); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: %0d outstanding want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic ax, ox, ir, ov; logic [OW-1:0] s;
        int stale;
        step(1'b1, {N{4'h7}}, 1'b1, ax, ox, ir, ov, s);
        step(1'b1, {N{4'h3}}, 1'b1, ax, ox, ir, ov, s);
        in_valid = 0; rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL rstmid_sum: got %0d want 0", out_sum); end
        rst = 1'b0;
        exp_q.delete();
        stale = 0;
        for (int t = 0; t < 10; t++) begin
            step(1'b0, '0, 1'b1, ax, ox, ir, ov, s);
            if (ov) stale++;
        end
        n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rstmid_stale: %0d outputs want 0", stale); end
    endtask

    task automatic test_wide();
        longint unsigned e;
        logic [31:0] op;
        @(posedge clk); #1;
        d2 = 2'b11; v2 = 1; d64 = '1; v64 = 1;
        @(posedge clk); #1;
        v2 = 0; v64 = 0;
        for (int t = 0; t < 20 && ov2 !== 1'b1; t++) begin @(posedge clk); #1; end
        n_checks++; if (ov2 !== 1'b1 || os2 !== OW2'(2)) begin n_fail++; $display("FAIL wide2: valid %b sum %0d want 1 2", ov2, os2); end
        for (int t = 0; t < 20 && ov64 !== 1'b1; t++) begin @(posedge clk); #1; end
        e = 64'd64 * 64'hFFFF_FFFF;
        n_checks++; if (ov64 !== 1'b1 || os64 !== OW64'(e)) begin n_fail++; $display("FAIL wide64_ones: valid %b sum %0d want 1 %0d", ov64, os64, e); end
        @(posedge clk); #1;
        e = 0;
        for (int i = 0; i < 64; i++) begin op = $urandom; d64[i*32 +: 32] = op; e += op; end
        v64 = 1;
        @(posedge clk); #1;
        v64 = 0;
        for (int t = 0; t < 20 && ov64 !== 1'b1; t++) begin @(posedge clk); #1; end
        n_checks++; if (ov64 !== 1'b1 || os64 !== OW64'(e)) begin n_fail++; $display("FAIL wide64_rand: valid %b sum %0d want 1 %0d", ov64, os64, e); end
        @(posedge clk); #1;
    endtask

`ifdef ADD_TREE_ACCUM_EN
    task automatic test_accum();
        int early, lat;
        early = 0;
        for (int b = 1; b <= 3; b++) begin
            av = 1; ad = {4{4'(b)}}; al = (b == 3);
            @(posedge clk); #1;
            if (aov) early++;
        end
        av = 0; al = 0;
        lat = 1;
        while (aov !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL acc_early: %0d outputs want 0", early); end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL acc_latency: got %0d want 3", lat); end
        n_checks++; if (aos !== 14'd24) begin n_fail++; $display("FAIL acc_sum: got %0d want 24", aos); end
        av = 1; ad = {4{4'd5}}; al = 1;
        @(posedge clk); #1;
        av = 0;
        for (int t = 0; t < 20 && aov !== 1'b1; t++) begin @(posedge clk); #1; end
        n_checks++; if (aov !== 1'b1 || aos !== 14'd20) begin n_fail++; $display("FAIL acc_restart: valid %b sum %0d want 1 20", aov, aos); end
        early = 0;
        for (int b = 0; b < 300; b++) begin
            av = 1; ad = 16'hFFFF; al = (b == 299);
            @(posedge clk); #1;
            if (aov && b > 0) early++;
        end
        av = 0; al = 0;
        for (int t = 0; t < 20 && aov !== 1'b1; t++) begin @(posedge clk); #1; end
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL acc_wrap_early: %0d outputs want 0", early); end
        n_checks++; if (aov !== 1'b1 || aos !== 14'((300 * 60) % (1 << 14))) begin
            n_fail++; $display("FAIL acc_wrap: valid %b sum %0d want 1 %0d", aov, aos, (300 * 60) % (1 << 14)); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_wide();
`ifdef ADD_TREE_ACCUM_EN
        test_accum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
